// File: rtl/tcp_tx_arb_pkg.sv
// Shared definitions for the SiTCP TCP transmit arbiter: FSM encoding,
// grant index width and default sizing.
package tcp_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } arb_state_t;

   // Grant index width; covers up to 8 requesters.
   localparam int GRANT_W = 3;

   localparam int N_SRC_DEFAULT = 4;
   localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Searches req upward from last_grant+1,
// wrapping modulo N_SRC, and returns the first requester found. Also used by
// the RBCP register bus sharing logic.
module rr_arbiter
   import tcp_tx_arb_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT
) (
   input  logic [N_SRC-1:0]   req,
   input  logic [GRANT_W-1:0] last_grant,
   output logic               gnt_valid,
   output logic [GRANT_W-1:0] gnt_idx
);

   logic               hi_found_s;
   logic [GRANT_W-1:0] hi_idx_s;
   logic               lo_found_s;
   logic [GRANT_W-1:0] lo_idx_s;

   // Split search: first requester above last_grant, else first at or below it.
   always_comb begin
      hi_found_s = 1'b0;
      hi_idx_s   = {GRANT_W{1'b0}};
      lo_found_s = 1'b0;
      lo_idx_s   = {GRANT_W{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         if (req[i] && (GRANT_W'(i) > last_grant) && !hi_found_s) begin
            hi_found_s = 1'b1;
            hi_idx_s   = GRANT_W'(i);
         end else begin
            hi_found_s = hi_found_s;
         end
         if (req[i] && (GRANT_W'(i) <= last_grant) && !lo_found_s) begin
            lo_found_s = 1'b1;
            lo_idx_s   = GRANT_W'(i);
         end else begin
            lo_found_s = lo_found_s;
         end
      end
      gnt_valid = hi_found_s | lo_found_s;
      if (hi_found_s) begin
         gnt_idx = hi_idx_s;
      end else begin
         gnt_idx = lo_idx_s;
      end
   end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Shares the SiTCP TCP transmit byte port between N_SRC producers. Grants are
// round-robin per frame; the almost-full flag pauses the current frame and a
// lost connection flushes the rest of the owning frame so sources stay
// frame-aligned. Flushed frames are counted in a saturating counter.
module tcp_tx_arbiter
   import tcp_tx_arb_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic                 SYSCLK,
   input  logic                 sitcp_reset_n,
   input  logic [N_SRC-1:0]     src_valid,
   input  logic [8*N_SRC-1:0]   src_data,
   input  logic [N_SRC-1:0]     src_last,
   output logic [N_SRC-1:0]     src_ready,
   input  logic                 tcp_open_ack,
   input  logic                 tcp_tx_full,
   output logic                 tcp_tx_wr,
   output logic [7:0]           tcp_tx_data,
   output logic [GRANT_W-1:0]   grant_id,
   output logic                 busy,
   output logic [CNT_W-1:0]     drop_cnt
);

   arb_state_t         state_r;
   logic [GRANT_W-1:0] last_grant_r;

   logic               arb_valid_s;
   logic [GRANT_W-1:0] arb_idx_s;
   logic               sel_valid_s;
   logic               sel_last_s;
   logic [7:0]         sel_data_s;

   rr_arbiter #(
      .N_SRC (N_SRC)
   ) u_rr (
      .req        (src_valid),
      .last_grant (last_grant_r),
      .gnt_valid  (arb_valid_s),
      .gnt_idx    (arb_idx_s)
   );

   // Route the current owner's valid/last/data to the FSM.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_data_s  = 8'h00;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_id == GRANT_W'(i)) begin
            sel_valid_s = src_valid[i];
            sel_last_s  = src_last[i];
            sel_data_s  = src_data[8*i +: 8];
         end else begin
            sel_valid_s = sel_valid_s;
         end
      end
   end

   // Ready only for the owner: throttled while streaming, always open while flushing.
   always_comb begin
      src_ready = {N_SRC{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_id == GRANT_W'(i)) begin
            case (state_r)
               STREAM:  src_ready[i] = src_valid[i] & tcp_open_ack & ~tcp_tx_full;
               FLUSH:   src_ready[i] = 1'b1;
               default: src_ready[i] = 1'b0;
            endcase
         end else begin
            src_ready[i] = 1'b0;
         end
      end
   end

   // Frame-level FSM with registered SiTCP write port, grant and drop counter.
   always_ff @(posedge SYSCLK) begin
      if (!sitcp_reset_n) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_W'(N_SRC - 1);
         grant_id     <= {GRANT_W{1'b0}};
         busy         <= 1'b0;
         tcp_tx_wr    <= 1'b0;
         tcp_tx_data  <= 8'h00;
         drop_cnt     <= {CNT_W{1'b0}};
      end else begin
         tcp_tx_wr <= 1'b0;
         case (state_r)
            IDLE: begin
               // No byte is taken in the grant cycle.
               if (tcp_open_ack && arb_valid_s) begin
                  grant_id     <= arb_idx_s;
                  last_grant_r <= arb_idx_s;
                  busy         <= 1'b1;
                  state_r      <= STREAM;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            STREAM: begin
               if (!tcp_open_ack) begin
                  state_r <= FLUSH;
               end else if (sel_valid_s && !tcp_tx_full) begin
                  tcp_tx_wr   <= 1'b1;
                  tcp_tx_data <= sel_data_s;
                  if (sel_last_s) begin
                     busy    <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     state_r <= STREAM;
                  end
               end else begin
                  state_r <= STREAM;
               end
            end
            FLUSH: begin
               // Discard bytes until the owner's frame ends, then count it.
               if (sel_valid_s && sel_last_s) begin
                  if (drop_cnt != {CNT_W{1'b1}}) begin
                     drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     drop_cnt <= drop_cnt;
                  end
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  state_r <= FLUSH;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Bench for tcp_tx_arbiter: per-source byte queues feed the DUT, expected
// output bytes go into a scoreboard queue and are checked on every write.
module tb_tcp_tx_arbiter;
   import tcp_tx_arb_pkg::*;

   localparam int NS = 4;

   logic SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   logic                 sitcp_reset_n;
   logic [NS-1:0]        src_valid, src_last, src_ready;
   logic [8*NS-1:0]      src_data;
   logic                 tcp_open_ack, tcp_tx_full, tcp_tx_wr;
   logic [7:0]           tcp_tx_data;
   logic [GRANT_W-1:0]   grant_id;
   logic                 busy;
   logic [15:0]          drop_cnt;

   // second instance: 2 sources, 4-bit drop counter
   logic [1:0]  d2_valid, d2_last, d2_ready;
   logic [15:0] d2_data;
   logic        d2_open, d2_full, d2_wr, d2_busy;
   logic [7:0]  d2_txd;
   logic [2:0]  d2_gid;
   logic [3:0]  d2_drop;

   tcp_tx_arbiter #(.N_SRC(NS), .CNT_W(16)) dut (
      .SYSCLK(SYSCLK), .sitcp_reset_n(sitcp_reset_n),
      .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
      .src_ready(src_ready), .tcp_open_ack(tcp_open_ack), .tcp_tx_full(tcp_tx_full),
      .tcp_tx_wr(tcp_tx_wr), .tcp_tx_data(tcp_tx_data), .grant_id(grant_id),
      .busy(busy), .drop_cnt(drop_cnt));

   tcp_tx_arbiter #(.N_SRC(2), .CNT_W(4)) dut2 (
      .SYSCLK(SYSCLK), .sitcp_reset_n(sitcp_reset_n),
      .src_valid(d2_valid), .src_data(d2_data), .src_last(d2_last),
      .src_ready(d2_ready), .tcp_open_ack(d2_open), .tcp_tx_full(d2_full),
      .tcp_tx_wr(d2_wr), .tcp_tx_data(d2_txd), .grant_id(d2_gid),
      .busy(d2_busy), .drop_cnt(d2_drop));

   // sources must hold data/last while stalled
   for (genvar gi = 0; gi < NS; gi++) begin : g_hold
      a_hold: assert property (@(posedge SYSCLK) disable iff (!sitcp_reset_n)
         (src_valid[gi] && !src_ready[gi]) |=>
         (!src_valid[gi] || ($stable(src_data[8*gi +: 8]) && $stable(src_last[gi]))))
         else $error("source %0d changed data while stalled", gi);
   end

   typedef struct {
      string frames;   // frames queued per source, digit per source 0..3
      string grants;   // expected grant order
   } rr_vec_t;

   rr_vec_t     vecs [6];
   logic [8:0]  sq [NS][$];     // {last, data}
   logic [7:0]  exp_q [$];
   logic [2:0]  glog [$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          n_wr = 0;
   logic        busy_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] fbase(input int s, input int r, input int f);
      return 8'(s*64 + r*8 + f*2);
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NS; i++) if (sq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_srcs();
      for (int i = 0; i < NS; i++) begin
         if (sq[i].size() > 0) begin
            src_valid[i]        = 1'b1;
            src_data[8*i +: 8]  = sq[i][0][7:0];
            src_last[i]         = sq[i][0][8];
         end else begin
            src_valid[i]        = 1'b0;
            src_data[8*i +: 8]  = 8'h00;
            src_last[i]         = 1'b0;
         end
      end
   endtask

   task automatic enqueue(input int s, input int len, input logic [7:0] base, input bit expect_out);
      for (int k = 0; k < len; k++) begin
         sq[s].push_back({(k == len-1), 8'(base + 8'(k))});
         if (expect_out) exp_q.push_back(8'(base + 8'(k)));
      end
   endtask

   // one clock: sample handshakes, advance, check the write port, redrive
   task automatic tick();
      logic [NS-1:0] hs;
      logic [8:0]    tmp;
      logic [7:0]    e;
      #1;
      hs = src_valid & src_ready;
      @(posedge SYSCLK);
      @(negedge SYSCLK);
      for (int i = 0; i < NS; i++) if (hs[i] && sq[i].size() > 0) tmp = sq[i].pop_front();
      if (tcp_tx_wr === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL tx_unexpected: got write of %02h, expected no write", tcp_tx_data);
         end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tcp_tx_data), 32'(e));
         end
      end
      if (busy && !busy_prev) glog.push_back(grant_id);
      busy_prev = busy;
      drive_srcs();
   endtask

   task automatic wait_drain(input int budget, output int cyc);
      cyc = 0;
      while (!(all_empty() && !busy && !tcp_tx_wr) && cyc < budget) begin
         tick();
         cyc++;
      end
      if (cyc >= budget) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d cycles, expected under %0d", cyc, budget);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, n, g, r, wr0;
      int fcnt [NS];

      vecs[0].frames = "2211"; vecs[0].grants = "012301";
      vecs[1].frames = "1010"; vecs[1].grants = "20";
      vecs[2].frames = "0103"; vecs[2].grants = "1333";
      vecs[3].frames = "0111"; vecs[3].grants = "123";
      vecs[4].frames = "0020"; vecs[4].grants = "22";
      vecs[5].frames = "1001"; vecs[5].grants = "30";

      sitcp_reset_n = 1'b0;
      tcp_open_ack = 1'b1; tcp_tx_full = 1'b0;
      d2_valid = 2'b01; d2_last = 2'b01; d2_data = 16'h00AA;
      d2_open = 1'b0; d2_full = 1'b0;
      drive_srcs();
      tick(); tick();
      chk("rst_wr", 32'(tcp_tx_wr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      sitcp_reset_n = 1'b1;

      // ---- 1: single 4-byte frame on source 0
      enqueue(0, 4, 8'h11, 1'b0);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      sq[0].delete();
      sq[0].push_back({1'b0, 8'h11}); sq[0].push_back({1'b0, 8'h22});
      sq[0].push_back({1'b0, 8'h33}); sq[0].push_back({1'b1, 8'h44});
      drive_srcs();
      tick();
      chk("t1_grant_busy", 32'(busy), 32'd1);
      chk("t1_grant_id", 32'(grant_id), 32'd0);
      chk("t1_grant_nowr", 32'(tcp_tx_wr), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t1_wr", 32'(tcp_tx_wr), 32'd1);
      end
      chk("t1_busy_end", 32'(busy), 32'd0);
      tick();
      chk("t1_wr_end", 32'(tcp_tx_wr), 32'd0);
      chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // ---- 2: round-robin table, from a fresh pointer
      sitcp_reset_n = 1'b0; tick(); sitcp_reset_n = 1'b1;
      busy_prev = 1'b0;
      for (r = 0; r < 6; r++) begin
         glog.delete();
         for (int s = 0; s < NS; s++) begin
            n = int'(vecs[r].frames.getc(s)) - 48;
            for (int f = 0; f < n; f++) enqueue(s, 2, fbase(s, r, f), 1'b0);
            fcnt[s] = 0;
         end
         for (int k = 0; k < vecs[r].grants.len(); k++) begin
            g = int'(vecs[r].grants.getc(k)) - 48;
            exp_q.push_back(fbase(g, r, fcnt[g]));
            exp_q.push_back(8'(fbase(g, r, fcnt[g]) + 8'd1));
            fcnt[g]++;
         end
         drive_srcs();
         wait_drain(200, cyc);
         chk("rr_cycles", 32'(cyc), 32'(3*vecs[r].grants.len() + 1));
         chk("rr_nframes", 32'(glog.size()), 32'(vecs[r].grants.len()));
         for (int k = 0; k < vecs[r].grants.len() && k < glog.size(); k++)
            chk("rr_grant", 32'(glog[k]), 32'(int'(vecs[r].grants.getc(k)) - 48));
         chk("rr_sb_empty", 32'(exp_q.size()), 32'd0);
      end

      // ---- 3: backpressure mid-frame (pointer is 0, source 1 wins)
      enqueue(1, 6, 8'hA1, 1'b1);
      drive_srcs();
      wr0 = n_wr;
      tick();
      chk("t3_grant", 32'(grant_id), 32'd1);
      tick(); tick();
      tcp_tx_full = 1'b1;
      #1;
      chk("t3_ready_full", 32'(src_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t3_wr_paused", 32'(tcp_tx_wr), 32'd0);
         chk("t3_grant_kept", 32'(grant_id), 32'd1);
         #1;
         chk("t3_ready_paused", 32'(src_ready), 32'd0);
      end
      tcp_tx_full = 1'b0;
      wait_drain(100, cyc);
      chk("t3_bytes", 32'(n_wr - wr0), 32'd6);
      chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // ---- 4: disconnect after byte 2 of 8 on source 2 (pointer is 1)
      enqueue(2, 8, 8'hC0, 1'b0);
      exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
      drive_srcs();
      tick();
      chk("t4_grant", 32'(grant_id), 32'd2);
      tick(); tick();
      tcp_open_ack = 1'b0;
      enqueue(3, 2, 8'hD0, 1'b1);
      enqueue(0, 2, 8'hE0, 1'b1);
      drive_srcs();
      #1;
      chk("t4_ready_closed", 32'(src_ready), 32'd0);
      n = 0;
      while (sq[2].size() > 0 && n < 20) begin
         tick();
         n++;
         chk("t4_flush_nowr", 32'(tcp_tx_wr), 32'd0);
         #1;
         if (sq[2].size() > 0) chk("t4_flush_ready", 32'(src_ready), 32'b0100);
      end
      chk("t4_flush_cycles", 32'(n), 32'd7);
      chk("t4_drop", 32'(drop_cnt), 32'd1);
      chk("t4_idle", 32'(busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_hold_idle", 32'(busy), 32'd0);
      end
      tcp_open_ack = 1'b1;
      tick();
      chk("t4_regrant_busy", 32'(busy), 32'd1);
      chk("t4_regrant_id", 32'(grant_id), 32'd3);
      wait_drain(100, cyc);
      chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

      // ---- 5: reset in the middle of a frame (pointer is 0, source 1 wins)
      for (int s = 0; s < NS; s++) enqueue(s, 3, 8'(8'h50 + 8'(16*s)), 1'b0);
      exp_q.push_back(8'h60);
      drive_srcs();
      tick();
      chk("t5_grant", 32'(grant_id), 32'd1);
      tick();
      sitcp_reset_n = 1'b0;
      tick();
      chk("t5_rst_wr", 32'(tcp_tx_wr), 32'd0);
      chk("t5_rst_data", 32'(tcp_tx_data), 32'd0);
      chk("t5_rst_grant", 32'(grant_id), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
      #1;
      chk("t5_rst_ready", 32'(src_ready), 32'd0);
      sitcp_reset_n = 1'b1;
      for (int s = 0; s < NS; s++) sq[s].delete();
      chk("t5_sb_empty_rst", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      glog.delete();
      busy_prev = busy;
      for (int s = 0; s < NS; s++) enqueue(s, 2, 8'(8'h80 + 8'(16*s)), 1'b1);
      drive_srcs();
      wait_drain(100, cyc);
      chk("t5_nframes", 32'(glog.size()), 32'd4);
      for (int k = 0; k < 4 && k < glog.size(); k++)
         chk("t5_grant_order", 32'(glog[k]), 32'(k));
      chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // ---- 6: 4-bit drop counter saturates (second instance)
      for (int k = 1; k <= 17; k++) begin
         d2_open = 1'b1; tick();
         d2_open = 1'b0; tick();
         tick();
         chk("t6_drop", 32'(d2_drop), 32'((k < 15) ? k : 15));
         chk("t6_nowr", 32'(d2_wr), 32'd0);
      end
      chk("t6_idle", 32'(d2_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
